soc_mem_responder: RTL and testbench

//  Bus responder for the CPU memory port: word-wide RAM with byte-lane write

---
 rtl/soc_mem_responder.sv | 153 +++++++++++++++
 tb/tb_soc_mem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/soc_mem_responder.sv
// CPU memory-port responder: byte-lane-strobed word RAM with 1-cycle registered reads.
// Optional IO page (LEDs, UART TX, timer) is built only when SOC_MEM_IO_EN is defined.
module soc_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter              INIT_FILE   = "",
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  logic [31:0]       ram [2**ADDR_W];
  logic [ADDR_W-1:0] word_idx;
  logic              io_hit;
  logic [1:0]        reg_sel;
  logic [31:0]       io_rdata;
  logic [31:0]       rdata_q, rdata_d;
  logic              unused_addr_bits;

  assign word_idx         = mem_addr[ADDR_W+1:2];
  assign io_hit           = mem_addr[31];
  assign reg_sel          = mem_addr[3:2];
  assign unused_addr_bits = &{1'b0, mem_addr[30:ADDR_W+2], mem_addr[1:0]};

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (!io_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) ram[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Array read happens before the same-edge write lands, giving old data.
  always_comb begin
    rdata_d = rdata_q;
    if (mem_rstrb) rdata_d = io_hit ? io_rdata : ram[word_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign mem_rdata = rdata_q;

`ifdef SOC_MEM_IO_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [7:0]        leds_q, leds_d;
  logic [31:0]       timer_q, timer_d;
  logic              busy;
  logic              io_wr0;
  logic              baud_end;

  assign busy     = (state_q != S_IDLE);
  assign io_wr0   = io_hit && mem_wstrb[0];
  assign baud_end = (baud_q == BAUD_W'(CLK_PER_BIT - 1));

  always_comb begin
    io_rdata = '0;
    case (reg_sel)
      2'd0:    io_rdata = {24'd0, leds_q};
      2'd2:    io_rdata = {31'd0, busy};
      2'd3:    io_rdata = timer_q;
      default: io_rdata = '0;
    endcase
  end

  always_comb begin
    leds_d  = leds_q;
    timer_d = timer_q + 32'd1;
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (io_wr0 && reg_sel == 2'd0) leds_d = mem_wdata[7:0];
    if (state_q == S_IDLE) begin
      if (io_wr0 && reg_sel == 2'd1) begin
        shift_d = mem_wdata[7:0];
        state_d = S_START;
        baud_d  = '0;
        bit_d   = '0;
      end
    end else if (baud_end) begin
      baud_d = '0;
      case (state_q)
        S_START: state_d = S_DATA;
        S_DATA: begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end
    // Line level is registered from the next state so it changes with the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      leds_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      leds_q  <= leds_d;
      timer_q <= timer_d;
    end
  end

  assign leds    = leds_q;
  assign uart_tx = tx_q;
`else
  assign io_rdata = '0;
  assign leds     = '0;
  assign uart_tx  = 1'b1;
`endif

endmodule

// File: tb/tb_soc_mem_responder.sv
// Directed bench for soc_mem_responder; IO-page steps run when SOC_MEM_IO_EN is defined,
// otherwise the disabled-IO behaviour is checked.
module tb_soc_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [7:0]  leds;
    logic        uart_tx;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    soc_mem_responder #(
        .ADDR_W      (10),
        .CLK_PER_BIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .leds      (leds),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    // Present one bus cycle, wait for its edge, then release strobes #1 later.
    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic r);
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_rstrb = r;
        @(posedge clk);
        #1;
        mem_wstrb = 4'h0;
        mem_rstrb = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

`ifdef SOC_MEM_IO_EN
    logic [31:0] t1;
    logic [9:0]  frame;
`endif

    initial begin
        rst       = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        mem_rstrb = 1'b0;
        bus(32'h0, 32'h0, 4'h0, 1'b0);
        bus(32'h0, 32'h0, 4'h0, 1'b0);
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_leds", {24'd0, leds}, 32'h0);
        chk("reset_tx", {31'd0, uart_tx}, 32'h1);
        rst = 1'b0;

        // Full-word write then read with one-cycle latency, value held afterwards
        bus(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("rdata_before_read", mem_rdata, 32'h0);
        bus(32'h10, 32'h0, 4'h0, 1'b1);
        chk("full_word_read", mem_rdata, 32'hDEADBEEF);
        bus(32'h14, 32'h0, 4'h0, 1'b0);
        chk("rdata_held", mem_rdata, 32'hDEADBEEF);

        // Lane-by-lane accumulation and single-lane overwrite
        bus(32'h20, 32'h0, 4'hF, 1'b0);
        bus(32'h20, 32'h44332211, 4'b0001, 1'b0);
        bus(32'h20, 32'h44332211, 4'b0010, 1'b0);
        bus(32'h20, 32'h44332211, 4'b0100, 1'b0);
        bus(32'h20, 32'h44332211, 4'b1000, 1'b0);
        bus(32'h20, 32'h0, 4'h0, 1'b1);
        chk("lane_accumulate", mem_rdata, 32'h44332211);
        bus(32'h20, 32'h00AA0000, 4'b0100, 1'b0);
        bus(32'h20, 32'h0, 4'h0, 1'b1);
        chk("single_lane", mem_rdata, 32'h44AA2211);
        bus(32'h23, 32'h0, 4'h0, 1'b1);
        chk("byte_offset_ignored", mem_rdata, 32'h44AA2211);

        // Read-during-write returns old data; upper address bits alias
        bus(32'h30, 32'h1, 4'hF, 1'b0);
        bus(32'h30, 32'h2, 4'hF, 1'b1);
        chk("rdw_old", mem_rdata, 32'h1);
        bus(32'h30, 32'h0, 4'h0, 1'b1);
        chk("rdw_new", mem_rdata, 32'h2);
        bus(32'h1030, 32'h0, 4'h0, 1'b1);
        chk("alias_read", mem_rdata, 32'h2);

        // IO writes never reach RAM word 0
        bus(32'h0, 32'h12345678, 4'hF, 1'b0);

`ifdef SOC_MEM_IO_EN
        bus(32'h80000000, 32'hFFFFFFA5, 4'b0001, 1'b0);
        chk("leds_write", {24'd0, leds}, 32'hA5);
        bus(32'h80000000, 32'h0000FF00, 4'b0010, 1'b0);
        chk("leds_lane1_ignored", {24'd0, leds}, 32'hA5);
        bus(32'h80000000, 32'h0, 4'h0, 1'b1);
        chk("leds_read", mem_rdata, 32'h000000A5);
        bus(32'h0, 32'h0, 4'h0, 1'b1);
        chk("io_not_in_ram", mem_rdata, 32'h12345678);

        bus(32'h8000000C, 32'h0, 4'h0, 1'b1);
        t1 = mem_rdata;
        for (int i = 0; i < 4; i++) bus(32'h0, 32'h0, 4'h0, 1'b0);
        bus(32'h8000000C, 32'h0, 4'h0, 1'b1);
        chk("timer_delta", mem_rdata - t1, 32'd5);

        bus(32'h80000004, 32'h0, 4'h0, 1'b1);
        chk("uart_data_reads_0", mem_rdata, 32'h0);

        // 0x55 frame: start, LSB-first data, stop; 4 clocks per bit
        frame = {1'b1, 8'h55, 1'b0};
        bus(32'h80000004, 32'h00000055, 4'b0001, 1'b0);
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("tx_bit%0d_c%0d", p, c), {31'd0, uart_tx}, {31'd0, frame[p]});
                if (p == 5 && c == 1) chk("stat_busy", mem_rdata, 32'h1);
                if (p == 2 && c == 0)      bus(32'h80000004, 32'h000000FF, 4'b0001, 1'b0);
                else if (p == 5 && c == 0) bus(32'h80000008, 32'h0, 4'h0, 1'b1);
                else                       bus(32'h0, 32'h0, 4'h0, 1'b0);
            end
        end
        chk("tx_idle_after", {31'd0, uart_tx}, 32'h1);
        bus(32'h80000008, 32'h0, 4'h0, 1'b1);
        chk("stat_idle", mem_rdata, 32'h0);

        // Reset mid-frame
        bus(32'h80000004, 32'h0000000F, 4'b0001, 1'b0);
        chk("tx_start_bit", {31'd0, uart_tx}, 32'h0);
        rst = 1'b1;
        bus(32'h0, 32'h0, 4'h0, 1'b0);
        rst = 1'b0;
        chk("rst_tx", {31'd0, uart_tx}, 32'h1);
        chk("rst_leds", {24'd0, leds}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        bus(32'h8000000C, 32'h0, 4'h0, 1'b1);
        chk("rst_timer", mem_rdata, 32'h0);
        bus(32'h80000008, 32'h0, 4'h0, 1'b1);
        chk("rst_stat", mem_rdata, 32'h0);
        bus(32'h0, 32'h0, 4'h0, 1'b0);
        chk("rst_tx_stays", {31'd0, uart_tx}, 32'h1);
`else
        bus(32'h80000000, 32'h000000A5, 4'hF, 1'b0);
        bus(32'h80000000, 32'h0, 4'h0, 1'b1);
        chk("io_off_read", mem_rdata, 32'h0);
        chk("io_off_leds", {24'd0, leds}, 32'h0);
        chk("io_off_tx", {31'd0, uart_tx}, 32'h1);
        bus(32'h80000004, 32'h00000055, 4'hF, 1'b0);
        bus(32'h0, 32'h0, 4'h0, 1'b1);
        chk("io_not_in_ram", mem_rdata, 32'h12345678);
        chk("io_off_tx_after", {31'd0, uart_tx}, 32'h1);
        rst = 1'b1;
        bus(32'h0, 32'h0, 4'h0, 1'b0);
        rst = 1'b0;
        chk("rst_rdata", mem_rdata, 32'h0);
`endif

        // RAM contents survive reset
        bus(32'h20, 32'h0, 4'h0, 1'b1);
        chk("ram_kept_20", mem_rdata, 32'h44AA2211);
        bus(32'h10, 32'h0, 4'h0, 1'b1);
        chk("ram_kept_10", mem_rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
